// File: rtl/mem_store_pkg.sv
// Shared definitions for the store router: funct3 codes, address region bits,
// the MMIO posting-queue entry and the byte-lane alignment helper.
package mem_store_pkg;

    localparam int DATA_W   = 32;
    localparam int WEA_W    = 4;
    localparam int CH_MAX_W = 6;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int DMEM_BIT = 28;
    localparam int IMEM_BIT = 29;
    localparam int MMIO_BIT = 31;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        logic [WEA_W-1:0]    wea;
        logic [DATA_W-1:0]   data;
    } mmio_entry_t;

    typedef struct packed {
        logic              known;
        logic              misaligned;
        logic [WEA_W-1:0]  wea;
        logic [DATA_W-1:0] data;
    } lane_t;

    // Byte-lane placement of a store; wea stays zero for unknown or misaligned stores.
    function automatic lane_t align_store(input logic [2:0]        funct3,
                                          input logic [1:0]        offs,
                                          input logic [DATA_W-1:0] rs2);
        lane_t lane;
        lane = '0;
        case (funct3)
            F3_SB: begin
                lane.known = 1'b1;
                lane.wea   = 4'b0001 << offs;
                lane.data  = {24'h0, rs2[7:0]} << {offs, 3'b000};
            end
            F3_SH: begin
                lane.known      = 1'b1;
                lane.misaligned = offs[0];
                lane.data       = offs[1] ? {rs2[15:0], 16'h0} : {16'h0, rs2[15:0]};
                if (!offs[0]) begin
                    lane.wea = offs[1] ? 4'b1100 : 4'b0011;
                end
            end
            F3_SW: begin
                lane.known      = 1'b1;
                lane.misaligned = (offs != 2'b00);
                lane.data       = rs2;
                if (offs == 2'b00) begin
                    lane.wea = 4'b1111;
                end
            end
            default: lane = '0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Small posting FIFO: registered pointers and occupancy, head visible combinationally.
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_store_router.sv
// Routes core stores to DMEM/IMEM byte enables or an MMIO posting queue,
// and flags misaligned or out-of-range channel stores.
module mem_store_router
    import mem_store_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DEPTH  = 4,
    parameter int CH_LSB = 2,
    localparam int IDX_W = $clog2(N_CH),
    localparam int CH_W  = (IDX_W > 0) ? IDX_W : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [2:0]               st_funct3,
    input  logic                     pc30,
    output logic                     st_stall,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               dmem_wea,
    output logic [3:0]               imem_wea,
    output logic                     mmio_valid,
    input  logic                     mmio_ready,
    output logic [CH_W-1:0]          mmio_ch,
    output logic [3:0]               mmio_wea,
    output logic [31:0]              mmio_wdata,
    output logic [N_CH-1:0]          mmio_pulse,
    output logic                     fault,
    output logic [31:0]              fault_addr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    lane_t               lane_p0;
    logic [CH_MAX_W-1:0] ch_idx_p0;
    logic                ch_bad_p0;
    logic                is_mmio_p0;
    logic                write_ok_p0;
    logic                push_p0;
    logic                pop_p0;
    logic                fault_p0;
    logic                fifo_full;
    logic                fifo_empty;
    mmio_entry_t         entry_in;
    mmio_entry_t         head;

    // Stage p0: decode and lane alignment, all combinational from the request.
    assign lane_p0 = align_store(st_funct3, st_addr[1:0], st_data);

    generate
        if (IDX_W == 0) begin : g_one_ch
            assign ch_idx_p0 = '0;
        end else begin : g_multi_ch
            assign ch_idx_p0 = CH_MAX_W'(st_addr[CH_LSB +: IDX_W]);
        end
    endgenerate

    assign is_mmio_p0  = st_addr[MMIO_BIT];
    assign ch_bad_p0   = ({1'b0, ch_idx_p0} >= 7'(N_CH));
    assign write_ok_p0 = st_valid & lane_p0.known & ~lane_p0.misaligned;

    assign mem_wdata = lane_p0.data;
    assign dmem_wea  = (write_ok_p0 & ~is_mmio_p0 & st_addr[DMEM_BIT]) ? lane_p0.wea : '0;
    assign imem_wea  = (write_ok_p0 & ~is_mmio_p0 & st_addr[IMEM_BIT] & pc30) ? lane_p0.wea : '0;

    // Stall depends only on registered occupancy, never on mmio_ready.
    assign st_stall = st_valid & lane_p0.known & is_mmio_p0 & fifo_full;

    assign push_p0  = write_ok_p0 & is_mmio_p0 & ~ch_bad_p0 & ~fifo_full & ~rst;
    assign fault_p0 = st_valid & lane_p0.known & ~st_stall &
                      (lane_p0.misaligned | (is_mmio_p0 & ch_bad_p0));

    assign entry_in.ch   = ch_idx_p0;
    assign entry_in.wea  = lane_p0.wea;
    assign entry_in.data = lane_p0.data;

    store_fifo #(
        .WIDTH ($bits(mmio_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_p0),
        .wdata (entry_in),
        .pop   (pop_p0),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head side: a reset cycle neither presents nor strobes a stale entry.
    assign mmio_valid = ~fifo_empty & ~rst;
    assign pop_p0     = mmio_valid & mmio_ready;
    assign mmio_ch    = head.ch[CH_W-1:0];
    assign mmio_wea   = head.wea;
    assign mmio_wdata = head.data;
    assign mmio_pulse = pop_p0 ? (N_CH'(1) << head.ch) : '0;

    // Stage p1: registered fault pulse and sticky captured address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault <= fault_p0;
            if (fault_p0) begin
                fault_addr <= st_addr;
            end
        end
    end

endmodule

// File: doc/mem_store_router.md
MEM_STORE_ROUTER -- requirements
Module: mem_store_router

Interface
REQ-001 Parameter N_CH, default 16, number of MMIO write channels (1..64).
REQ-002 Parameter DEPTH, default 4, MMIO posting-FIFO depth in entries (power of two, >=2).
REQ-003 Parameter CH_LSB, default 2, lowest address bit of the channel index field (index = addr[CH_LSB +: clog2(N_CH)]).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 st_valid  in  1  store request from the core, held while st_stall=1.
REQ-008 st_addr  in  32  store byte address.
REQ-009 st_data  in  32  rs2 value.
REQ-010 st_funct3  in  3  store width (SB=000, SH=001, SW=010).
REQ-011 pc30  in  1  PC bit 30; gates IMEM writes.
REQ-012 st_stall  out  1  request not accepted this cycle.
REQ-013 mem_wdata  out  32  lane-aligned store data.
REQ-014 dmem_wea / imem_wea  out  4 each  BRAM byte write enables.
REQ-015 mmio_valid  out  1  FIFO head valid.
REQ-016 mmio_ready  in  1  peripheral side accepts head.
REQ-017 mmio_ch  out  clog2(N_CH)  head channel index.
REQ-018 mmio_wea / mmio_wdata  out  4 / 32  head byte enables and aligned data.
REQ-019 mmio_pulse  out  N_CH  one-hot strobe, channel written this cycle.
REQ-020 fault / fault_addr  out  1 / 32  misaligned or undecoded store pulse and captured address.
REQ-021 fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-022 Lane alignment: SB -> wea=1<<addr[1:0], byte replicated into that lane, other lanes 0; SH -> wea=0011/1100 by addr[1]; SW -> 1111, data unchanged.
REQ-023 Other funct3 values SHALL produce no write, no enqueue, no fault, no stall.
REQ-024 Misaligned (SH with addr[0]=1, SW with addr[1:0]!=0) SHALL write nothing and raise fault.
REQ-025 dmem_wea = wea when addr[28]=1; imem_wea = wea when addr[29]=1 and pc30=1; both combinational, same cycle as st_valid.
REQ-026 addr[31]=1 stores SHALL be enqueued (ch, wea, data) when FIFO not full; never written to DMEM/IMEM.
REQ-027 Channel index >= N_CH SHALL be dropped with fault.
REQ-028 st_stall = st_valid & addr[31] & full; no combinational path from mmio_ready to st_stall.
REQ-029 Enqueue into empty FIFO: mmio_valid asserts on the next cycle (latency 1).
REQ-030 Pop on mmio_valid & mmio_ready; mmio_pulse[mmio_ch] high in that same cycle only; mmio_pulse all-zero otherwise.
REQ-031 Simultaneous push and pop: count unchanged, ordering FIFO.
REQ-032 Full: push refused (stall), pop proceeds; empty: mmio_valid=0, ready ignored.
REQ-033 fault is a one-cycle registered pulse the cycle after the offending request; fault_addr updates only on fault and holds otherwise.
REQ-034 Pointers wrap modulo DEPTH.

Reset
REQ-035 On rst: FIFO pointers and count 0, mmio_valid 0, mmio_pulse 0, fault 0, fault_addr 0.
REQ-036 Reset mid-operation SHALL discard all queued entries; no mmio_pulse in the reset cycle.
REQ-037 Combinational memory enables follow inputs regardless of rst; the core guarantees st_valid=0 during reset.

Structure
REQ-038 Package mem_store_pkg SHALL hold funct3 constants, region bit positions (28, 29, 31) and the FIFO entry struct.
REQ-039 FIFO SHALL be a sub-module store_fifo (parameter WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-040 SB addr 0x1000_0003 data 0x0000_00A5 -> dmem_wea=1000, mem_wdata=0xA500_0000, no MMIO activity.
REQ-041 SW addr 0x2000_0010, pc30=0 then 1 -> imem_wea 0000 then 1111.
REQ-042 SW 0x8000_0008 data 0x41, mmio_ready=1 -> mmio_valid next cycle, mmio_ch=2, mmio_pulse=0x0004 one cycle.
REQ-043 mmio_ready=0, 5 MMIO SW back-to-back (DEPTH=4) -> 5th stalls, fifo_count=4; release ready -> 4 pulses in order, then 5th accepted.
REQ-044 SH addr 0x1000_0001 -> dmem_wea=0000, fault next cycle, fault_addr=0x1000_0001.
REQ-045 FIFO count 3, assert rst one cycle -> fifo_count=0, mmio_valid=0, no pulses after.
